// File: rtl/axis_dm_pkg.sv
// Shared definitions for the DataMover command generator: command/status field
// positions, the controller state encoding and the command packing helper.
package axis_dm_pkg;

   localparam int CMD_BTT_MSB   = 22;
   localparam int CMD_INCR_BIT  = 23;
   localparam int CMD_DSA_LSB   = 24;
   localparam int CMD_DSA_MSB   = 29;
   localparam int CMD_EOF_BIT   = 30;
   localparam int CMD_DRR_BIT   = 31;
   localparam int CMD_ADDR_LSB  = 32;
   localparam int CMD_MAX_WIDTH = 104;

   localparam int STS_TAG_MSB    = 3;
   localparam int STS_INTERR_BIT = 4;
   localparam int STS_DECERR_BIT = 5;
   localparam int STS_SLVERR_BIT = 6;
   localparam int STS_OKAY_BIT   = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_HS = 2'd2,
      ST_DRAIN   = 2'd3
   } dm_state_e;

   // Builds a command for the widest address; the tag lands just above the
   // address field, so the caller passes the real address width.
   function automatic logic [CMD_MAX_WIDTH-1:0] pack_dm_cmd(
      input logic [63:0] addr,
      input logic [22:0] btt,
      input logic [3:0]  tag,
      input int          addr_w
   );
      logic [CMD_MAX_WIDTH-1:0] cmd;
      cmd                           = '0;
      cmd[CMD_BTT_MSB:0]            = btt;
      cmd[CMD_INCR_BIT]             = 1'b1;
      cmd[CMD_DSA_MSB:CMD_DSA_LSB]  = 6'd0;
      cmd[CMD_EOF_BIT]              = 1'b1;
      cmd[CMD_DRR_BIT]              = 1'b0;
      cmd = cmd | ({40'd0, addr} << CMD_ADDR_LSB)
                | ({100'd0, tag} << (CMD_ADDR_LSB + addr_w));
      return cmd;
   endfunction

endpackage

// File: rtl/axis_dm_sts_mon.sv
// Status-stream monitor: tracks commands in flight, the tag expected on the
// next status beat, and flags malformed or unexpected status.
module axis_dm_sts_mon
   import axis_dm_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       srst,
   input  logic       cmd_hs,
   input  logic       sts_valid,
   input  logic [7:0] sts_data,
   output logic       sts_ready,
   output logic       can_issue,
   output logic       none_outstanding,
   output logic       err_pulse,
   output logic       abort_pulse
);

   logic [3:0] outstanding_q, outstanding_d;
   logic [3:0] exp_tag_q, exp_tag_d;
   logic       sts_ready_q, sts_ready_d;
   logic       sts_hs_s, expected_s, bad_s;

   assign sts_hs_s   = sts_valid & sts_ready_q;
   assign expected_s = (outstanding_q != 4'd0);
   assign bad_s      = (sts_data[STS_TAG_MSB:0] != exp_tag_q) | ~sts_data[STS_OKAY_BIT]
                     | sts_data[STS_INTERR_BIT] | sts_data[STS_DECERR_BIT]
                     | sts_data[STS_SLVERR_BIT];

   assign err_pulse        = ~srst & sts_hs_s & (~expected_s | bad_s);
   assign abort_pulse      = ~srst & sts_hs_s & expected_s & bad_s;
   assign can_issue        = (outstanding_q < 4'(MAX_OUTSTANDING));
   assign none_outstanding = ~expected_s;
   assign sts_ready        = sts_ready_q;

   // Next-state for the in-flight counter and expected tag.
   always_comb begin
      outstanding_d = outstanding_q;
      exp_tag_d     = exp_tag_q;
      sts_ready_d   = 1'b1;
      if (srst) begin
         outstanding_d = 4'd0;
         exp_tag_d     = 4'd0;
      end else begin
         exp_tag_d = (sts_hs_s && expected_s) ? exp_tag_q + 4'd1 : exp_tag_q;
         case ({cmd_hs, sts_hs_s && expected_s})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
         endcase
      end
   end

   // Monitor state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= 4'd0;
         exp_tag_q     <= 4'd0;
         sts_ready_q   <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         exp_tag_q     <= exp_tag_d;
         sts_ready_q   <= sts_ready_d;
      end
   end

endmodule

// File: rtl/axis_cmd_gen_dm.sv
// DataMover command generator: splits a region into bursts, issues one
// command per burst with flow control, supports one-shot and ring operation.
module axis_cmd_gen_dm
   import axis_dm_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int BTT_WIDTH       = 23,
   parameter int MAX_BURST_LEN   = 4096,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CMD_WIDTH       = ADDR_WIDTH + 40
) (
   input  logic                  clk,
   input  logic                  resetn,
   output logic [CMD_WIDTH-1:0]  m_axis_cmd_tdata,
   output logic                  m_axis_cmd_tvalid,
   input  logic                  m_axis_cmd_tready,
   input  logic [7:0]            s_axis_sts_tdata,
   input  logic                  s_axis_sts_tvalid,
   output logic                  s_axis_sts_tready,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  soft_reset,
   input  logic                  ring_mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [31:0]           total_size,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           wrap_cnt
);

   localparam logic [31:0] MAX_BURST = 32'(MAX_BURST_LEN);

   dm_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d;
   logic [31:0]           rem_q, rem_d, total_q, total_d;
   logic                  ring_q, ring_d;
   logic [3:0]            tag_q, tag_d;
   logic                  tvalid_q, tvalid_d;
   logic [CMD_WIDTH-1:0]  tdata_q, tdata_d;
   logic                  done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic                  stop_pend_q, stop_pend_d;
   logic [15:0]           wrap_q, wrap_d;

   logic [31:0]              burst_s;
   logic                     last_s, cmd_hs_s, stop_req_s;
   logic                     can_issue_s, none_out_s, err_pulse_s, abort_s;
   logic [CMD_MAX_WIDTH-1:0] cmd_full_s;

   assign burst_s    = (rem_q < MAX_BURST) ? rem_q : MAX_BURST;
   assign last_s     = (rem_q <= MAX_BURST);
   assign cmd_hs_s   = tvalid_q & m_axis_cmd_tready;
   assign stop_req_s = stop_pend_q | stop | abort_s;
   assign cmd_full_s = pack_dm_cmd(64'(addr_q), 23'(burst_s[BTT_WIDTH-1:0]), tag_q, ADDR_WIDTH);

   axis_dm_sts_mon #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_sts_mon (
      .clk              (clk),
      .rst_n            (resetn),
      .srst             (soft_reset),
      .cmd_hs           (cmd_hs_s),
      .sts_valid        (s_axis_sts_tvalid),
      .sts_data         (s_axis_sts_tdata),
      .sts_ready        (s_axis_sts_tready),
      .can_issue        (can_issue_s),
      .none_outstanding (none_out_s),
      .err_pulse        (err_pulse_s),
      .abort_pulse      (abort_s)
   );

   // Controller next-state and output logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      base_d      = base_q;
      rem_d       = rem_q;
      total_d     = total_q;
      ring_d      = ring_q;
      tag_d       = tag_q;
      tvalid_d    = tvalid_q;
      tdata_d     = tdata_q;
      done_d      = done_q;
      err_d       = err_q | err_pulse_s;
      wrap_d      = wrap_q;
      stop_pend_d = stop_pend_q | abort_s | ((state_q != ST_IDLE) & stop);
      if (soft_reset) begin
         state_d     = ST_IDLE;
         addr_d      = '0;
         base_d      = '0;
         rem_d       = 32'd0;
         total_d     = 32'd0;
         ring_d      = 1'b0;
         tag_d       = 4'd0;
         tvalid_d    = 1'b0;
         tdata_d     = '0;
         done_d      = 1'b0;
         err_d       = 1'b0;
         wrap_d      = 16'd0;
         stop_pend_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  base_d      = base_addr;
                  addr_d      = base_addr;
                  total_d     = total_size;
                  rem_d       = total_size;
                  ring_d      = ring_mode;
                  err_d       = err_pulse_s;
                  wrap_d      = 16'd0;
                  stop_pend_d = 1'b0;
                  // An empty region completes without touching the DataMover.
                  done_d      = (total_size == 32'd0);
                  state_d     = (total_size == 32'd0) ? ST_IDLE : ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (stop_req_s) begin
                  state_d = ST_DRAIN;
               end else if (can_issue_s) begin
                  tdata_d  = cmd_full_s[CMD_WIDTH-1:0];
                  tvalid_d = 1'b1;
                  state_d  = ST_WAIT_HS;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
            ST_WAIT_HS: begin
               if (cmd_hs_s) begin
                  tvalid_d = 1'b0;
                  tag_d    = tag_q + 4'd1;
                  if (!last_s) begin
                     addr_d  = addr_q + ADDR_WIDTH'(burst_s);
                     rem_d   = rem_q - burst_s;
                     state_d = ST_ISSUE;
                  end else if (ring_q && !stop_req_s) begin
                     addr_d  = base_q;
                     rem_d   = total_q;
                     wrap_d  = (wrap_q != 16'hFFFF) ? wrap_q + 16'd1 : wrap_q;
                     state_d = ST_ISSUE;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  state_d = ST_WAIT_HS;
               end
            end
            ST_DRAIN: begin
               if (none_out_s) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // Controller registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         base_q      <= '0;
         rem_q       <= 32'd0;
         total_q     <= 32'd0;
         ring_q      <= 1'b0;
         tag_q       <= 4'd0;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         wrap_q      <= 16'd0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         rem_q       <= rem_d;
         total_q     <= total_d;
         ring_q      <= ring_d;
         tag_q       <= tag_d;
         tvalid_q    <= tvalid_d;
         tdata_q     <= tdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         wrap_q      <= wrap_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   assign m_axis_cmd_tdata  = tdata_q;
   assign m_axis_cmd_tvalid = tvalid_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign err               = err_q;
   assign wrap_cnt          = wrap_q;

endmodule
